ccm_ctr_in_framer: RTL

Upstream framing stage for the CCM counter-mode encrypt/XOR block. It accepts a byte stream from the packet source with a valid/ready handshake and buffers it in a small FIFO. It meters bytes into the CTR block only while that block reports ready, and enforces a maximum packet length. It holds off the next packet until the CTR block has emitted the last byte of the current one, because the CTR counter restarts per packet.

---
 rtl/ccm_ctr_in_framer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ccm_ctr_in_framer.sv
// ccm_ctr_in_framer: buffers a source byte stream and meters packets into the CCM CTR block.
// Optional statistics outputs pkt_cnt/drop_cnt are enabled with `define CCM_IN_FRAMER_STAT_EN.
module ccm_ctr_in_framer #(
    parameter int WIDTH     = 8,
    parameter int FIFO_AW   = 4,
    parameter int MAX_LEN   = 4096,
    parameter int WIDTH_LEN = 13
) (
    input  logic             clk,
    input  logic             kill,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_en,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             ctr_ready,
    input  logic             ctr_done,
    output logic [WIDTH-1:0] input_data,
    output logic             input_en,
    output logic             input_last,
    output logic             busy,
    output logic             len_err
`ifdef CCM_IN_FRAMER_STAT_EN
    ,
    output logic [15:0]      pkt_cnt,
    output logic [15:0]      drop_cnt
`endif
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, XFER, DROP, WAIT_DONE} state_t;

    state_t               state, state_n;
    logic [WIDTH:0]       mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     occ;
    logic [WIDTH_LEN-1:0] cnt, cnt_n;
    logic                 empty, full, push, pop, fwd, over, head_last;
    logic [WIDTH-1:0]     head_data;

    assign empty                 = occ == '0;
    assign full                  = occ == (FIFO_AW+1)'(DEPTH);
    assign s_ready               = kill & !full;
    assign push                  = s_en & s_ready;
    assign {head_last, head_data} = mem[rd_ptr];
    assign busy                  = (state != IDLE) | !empty;

    // FIFO storage: {last, data} per entry, no reset needed on the array
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_last, s_data};
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge clk) begin
        if (!kill) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            wr_ptr <= wr_ptr + FIFO_AW'(push);
            rd_ptr <= rd_ptr + FIFO_AW'(pop);
            occ    <= occ + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    // Packet FSM: forward while CTR is ready, drop the tail of over-length packets, then wait for CTR to finish
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        fwd     = 1'b0;
        over    = 1'b0;
        case (state)
            IDLE, XFER: begin
                if (!empty && ctr_ready) begin
                    pop     = 1'b1;
                    fwd     = 1'b1;
                    cnt_n   = (state == IDLE) ? WIDTH_LEN'(1) : cnt + 1'b1;
                    over    = !head_last && cnt_n == WIDTH_LEN'(MAX_LEN);
                    state_n = head_last ? WAIT_DONE : over ? DROP : XFER;
                end
            end
            DROP: begin
                pop     = !empty;
                state_n = (!empty && head_last) ? WAIT_DONE : DROP;
            end
            WAIT_DONE: begin
                state_n = ctr_done ? IDLE : WAIT_DONE;
                cnt_n   = ctr_done ? '0 : cnt;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, count and registered CTR-side outputs; a truncated packet gets its last flag forced
    always_ff @(posedge clk) begin
        if (!kill) begin
            state      <= IDLE;
            cnt        <= '0;
            input_en   <= 1'b0;
            input_last <= 1'b0;
            input_data <= '0;
            len_err    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            input_en   <= fwd;
            input_last <= fwd & (head_last | over);
            if (fwd) input_data <= head_data;
            if (over) len_err <= 1'b1;
        end
    end

`ifdef CCM_IN_FRAMER_STAT_EN
    // Packet and dropped-byte statistics, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (!kill) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (state_n == WAIT_DONE && state != WAIT_DONE) pkt_cnt <= pkt_cnt + 16'd1;
            if (state == DROP && pop) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif
endmodule
